j1_io_uart: RTL and testbench



---
 rtl/j1_io_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/j1_io_uart.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_j1_io_uart.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
// Shared definitions for peripherals on the J1 I/O port.
package j1_io_pkg;

  localparam logic [15:0] IO_UART_DATA = 16'h0000;
  localparam logic [15:0] IO_UART_STAT = 16'h0002;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_RX_FRAME  = 4;
  localparam int ST_TX_DROP   = 5;
  localparam int STATUS_W     = 6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; a pop in the same cycle frees
// the slot for a push into a full FIFO.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

endmodule

// File: rtl/j1_io_uart.sv
// UART responder on the J1 I/O port: DATA/STATUS registers, FIFO-buffered
// 8N1 transmitter and single-byte 8N1 receiver.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a FIFO byte
// TX_START | driving the start bit
// TX_DATA  | shifting eight data bits, LSB first
// TX_STOP  | driving the stop bit; chains straight to TX_START if data waits
// RX_IDLE  | waiting for a low on the synchronized line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sampling eight data bits at mid-bit
// RX_STOP  | sampling the stop bit and completing the byte
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h1000,
  parameter int          CLKS_PER_BIT = 217,
  parameter int          TX_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  output logic             uart_tx,
  input  logic             uart_rx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   DATA_ADDR = BASE_ADDR + IO_UART_DATA;
  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + IO_UART_STAT;

  logic sel_data, sel_stat;
  logic data_rd, data_wr, stat_rd, stat_wr;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_idle;

  logic          rx_s1_q, rx_s2_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_done;

  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_frame_q, rx_frame_d;
  logic          tx_drop_q, tx_drop_d;
  logic [STATUS_W-1:0] status;

  logic unused_dout_hi;
  assign unused_dout_hi = ^dout[WIDTH-1:8];

  assign sel_data = (mem_addr == DATA_ADDR);
  assign sel_stat = (mem_addr == STAT_ADDR);
  assign data_rd  = io_rd & sel_data;
  assign data_wr  = io_wr & sel_data;
  assign stat_rd  = io_rd & sel_stat;
  assign stat_wr  = io_wr & sel_stat;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (data_wr),
    .pop     (fifo_pop),
    .wr_data (dout[7:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LOAD;
          tx_shift_d = fifo_rd_data;
          fifo_pop   = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LOAD;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LOAD;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!fifo_empty) begin
            tx_state_d = TX_START;
            tx_cnt_d   = BIT_LOAD;
            tx_shift_d = fifo_rd_data;
            fifo_pop   = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
    endcase

    // Line is registered from the current state, one cycle behind it.
    case (tx_state_q)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_q[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_idle = fifo_empty && (tx_state_q == TX_IDLE);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LOAD;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LOAD;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Clears apply first so a same-cycle set event wins.
  always_comb begin
    rx_valid_d   = rx_valid_q & ~data_rd;
    rx_byte_d    = rx_byte_q;
    rx_overrun_d = rx_overrun_q & ~(stat_wr & dout[ST_RX_OVERRUN]);
    rx_frame_d   = rx_frame_q & ~(stat_wr & dout[ST_RX_FRAME]);
    tx_drop_d    = tx_drop_q & ~(stat_wr & dout[ST_TX_DROP]);
    if (rx_done) begin
      if (!rx_s2_q) begin
        rx_frame_d = 1'b1;
      end else if (rx_valid_d) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
    if (data_wr && fifo_full && !fifo_pop) begin
      tx_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      rx_overrun_q <= 1'b0;
      rx_frame_q   <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      rx_overrun_q <= rx_overrun_d;
      rx_frame_q   <= rx_frame_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  always_comb begin
    status                = '0;
    status[ST_RX_VALID]   = rx_valid_q;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = tx_idle;
    status[ST_RX_OVERRUN] = rx_overrun_q;
    status[ST_RX_FRAME]   = rx_frame_q;
    status[ST_TX_DROP]    = tx_drop_q;
    io_din = '0;
    if (data_rd) begin
      io_din[7:0] = rx_byte_q;
    end else if (stat_rd) begin
      io_din[STATUS_W-1:0] = status;
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Bench for j1_io_uart: frame-timing model of the transmitter and register
// model of the flags, compared every cycle, plus directed literal checks.
module tb_j1_io_uart;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 4;
  localparam int          FRAME  = 10 * CPB;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h1002;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] dout = 16'h0;
  logic [15:0] io_din;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  always #5 clk = ~clk;

  j1_io_uart #(
    .WIDTH        (16),
    .BASE_ADDR    (16'h1000),
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .mem_addr (mem_addr),
    .dout     (dout),
    .io_din   (io_din),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: transmitter as a queue plus frame start times; flags as bits.
  int         cyc = 0;
  logic [7:0] m_q[$];
  int         next_pop = 0;
  bit         in_frame = 0;
  int         cur_start = 0;
  logic [7:0] cur_byte = 8'h0;
  bit         m_valid = 0, m_ovr = 0, m_fe = 0, m_drop = 0;
  logic [7:0] m_rxb = 8'h0;
  bit         rx_pend = 0;
  logic [7:0] pend_byte = 8'h0;
  bit         pend_stop = 0;
  bit         check_en = 0;

  function automatic logic exp_line();
    int k;
    if (in_frame && cyc >= cur_start && cyc < cur_start + FRAME) begin
      k = (cyc - cur_start) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return cur_byte[k-1];
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[0] = m_valid;
    s[1] = (m_q.size() == DEPTH);
    s[2] = (m_q.size() == 0) && (cyc >= next_pop);
    s[3] = m_ovr;
    s[4] = m_fe;
    s[5] = m_drop;
    return s;
  endfunction

  function automatic logic [15:0] exp_din();
    if (io_rd && mem_addr == A_DATA) return {8'h00, m_rxb};
    if (io_rd && mem_addr == A_STAT) return m_status();
    return 16'h0;
  endfunction

  always @(posedge clk) begin
    bit drop_set;
    cyc = cyc + 1;
    if (reset) begin
      m_q.delete();
      next_pop = 0;
      in_frame = 0;
      m_valid = 0; m_ovr = 0; m_fe = 0; m_drop = 0;
      m_rxb = 8'h0;
    end else begin
      if (m_q.size() > 0 && cyc >= next_pop) begin
        cur_byte  = m_q.pop_front();
        cur_start = cyc + 1;
        in_frame  = 1;
        next_pop  = cyc + FRAME;
      end
      drop_set = 0;
      if (io_wr && mem_addr == A_DATA) begin
        if (m_q.size() < DEPTH) m_q.push_back(dout[7:0]);
        else drop_set = 1;
      end
      if (io_wr && mem_addr == A_STAT) begin
        if (dout[3]) m_ovr = 0;
        if (dout[4]) m_fe = 0;
        if (dout[5]) m_drop = 0;
      end
      if (drop_set) m_drop = 1;
      if (io_rd && mem_addr == A_DATA) m_valid = 0;
      if (rx_pend) begin
        if (!pend_stop) m_fe = 1;
        else if (m_valid) m_ovr = 1;
        else begin
          m_rxb = pend_byte;
          m_valid = 1;
        end
        rx_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("uart_tx", {31'h0, uart_tx}, {31'h0, exp_line()});
      chk("io_din", {16'h0, io_din}, {16'h0, exp_din()});
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; mem_addr = a; dout = d;
    @(posedge clk); #1;
    io_wr = 1'b0; mem_addr = 16'h0; dout = 16'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    io_rd = 1'b1; mem_addr = a;
    @(negedge clk);
    v = io_din;
    @(posedge clk); #1;
    io_rd = 1'b0; mem_addr = 16'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
    idle(3 * CPB);
    pend_byte = b; pend_stop = stop; rx_pend = 1;
    idle(1);
  endtask

  initial begin
    logic [15:0] v;
    logic [9:0]  lv;
    logic [7:0]  rb;
    int          op;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_en = 1;

    // 1: reset state and unaddressed read
    rd(A_STAT, v);      chk("reset_status", {16'h0, v}, 32'h0004);
    chk("reset_tx", {31'h0, uart_tx}, 32'h1);
    rd(16'h2000, v);    chk("unmapped_rd", {16'h0, v}, 32'h0000);

    // 2: single byte waveform
    wr(A_DATA, 16'h00A5);
    @(negedge clk); chk("tx_e0", {31'h0, uart_tx}, 32'h1);
    @(negedge clk); chk("tx_e1", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    lv = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        chk("tx_a5_bit", {31'h0, uart_tx}, {31'h0, lv[k]});
        @(negedge clk);
      end
    end
    chk("tx_after_frame", {31'h0, uart_tx}, 32'h1);
    @(posedge clk); #1;
    rd(A_STAT, v);      chk("idle_after_a5", {16'h0, v}, 32'h0004);

    // 3: burst of six, last dropped
    for (int i = 1; i <= 6; i++) wr(A_DATA, 16'(i));
    rd(A_STAT, v);      chk("burst_full_drop", {16'h0, v}, 32'h0022);
    idle(5 * FRAME + 10);
    rd(A_STAT, v);      chk("burst_drained", {16'h0, v}, 32'h0024);
    wr(A_STAT, 16'h0020);
    rd(A_STAT, v);      chk("drop_cleared", {16'h0, v}, 32'h0004);

    // push into full FIFO in the same cycle as a pop is accepted
    for (int i = 0; i < 5; i++) wr(A_DATA, 16'(8'hC0 + i));
    idle(FRAME - 4);
    wr(A_DATA, 16'h00C5);
    rd(A_STAT, v);      chk("push_on_pop", {16'h0, v}, 32'h0002);
    idle(6 * FRAME);

    // 4: receive one byte
    rx_frame(8'h3C, 1'b1);
    rd(A_STAT, v);      chk("rx_valid", {16'h0, v}, 32'h0005);
    rd(A_DATA, v);      chk("rx_data_3c", {16'h0, v}, 32'h003C);
    rd(A_STAT, v);      chk("rx_valid_clr", {16'h0, v}, 32'h0004);

    // 5: overrun keeps first byte
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rd(A_DATA, v);      chk("ovr_data", {16'h0, v}, 32'h0011);
    rd(A_STAT, v);      chk("ovr_status", {16'h0, v}, 32'h000C);
    wr(A_STAT, 16'h0008);
    rd(A_STAT, v);      chk("ovr_cleared", {16'h0, v}, 32'h0004);

    // 6: framing error, then glitch
    rx_frame(8'h5A, 1'b0);
    rd(A_STAT, v);      chk("frame_err", {16'h0, v}, 32'h0014);
    uart_rx = 1'b0; idle(1); uart_rx = 1'b1; idle(4 * CPB);
    rd(A_STAT, v);      chk("glitch_ignored", {16'h0, v}, 32'h0014);
    wr(A_STAT, 16'h0010);
    rd(A_STAT, v);      chk("fe_cleared", {16'h0, v}, 32'h0004);

    // random CPU traffic against the transmitter model
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1: wr(A_DATA, 16'($urandom));
        2: rd(A_STAT, v);
        3: wr(A_STAT, 16'($urandom_range(0, 63)));
        4: idle($urandom_range(1, 30));
        5: rd(16'h2000 | 16'($urandom_range(0, 255)), v);
        default: rd(A_DATA, v);
      endcase
    end
    idle(6 * FRAME);

    // random receive frames
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rx_frame(rb, $urandom_range(0, 3) != 0);
      op = $urandom_range(0, 3);
      case (op)
        0: rd(A_DATA, v);
        1: rd(A_STAT, v);
        2: wr(A_STAT, 16'($urandom_range(0, 63)));
        default: idle(1);
      endcase
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
